evt_apb_reader: RTL and testbench
=================================

Name: evt_apb_reader

Overview:
- APB completer that fronts the event counter.
- Turns APB reads into req/atomic/ack handshakes toward the counter and returns the captured count as PRDATA.
- Acts as the initiator/reader end of the counter's req_i/atomic_i/ack_o/count_o interface.
- Sits between the system APB fabric and the event-counting block.

Parameters:
- ADDR_W, 4, APB address width (byte address; only bits [3:2] decoded).
- DATA_W, 32, data width; matches counter count width.
- TIMEOUT_CYCLES, 16, max cycles waiting for ack before error (used only with optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_W  APB address.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1=write, 0=read.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data, registered.
- pready  out  1  APB ready, registered, one-cycle pulse.
- pslverr  out  1  APB error, valid with pready.
- req_o  out  1  request to counter, level, held until ack_i.
- atomic_o  out  1  1=read-and-clear request, stable while req_o=1.
- ack_i  in  1  counter acknowledge, single-cycle pulse.
- count_i  in  DATA_W  counter value, valid in ack_i cycle.

Behaviour:
- Reset (rst=0, async): prdata=0, pready=0, pslverr=0, req_o=0, atomic_o=0; last_q=0, scratch_q=0; FSM=IDLE.
- Register map (offset):
  - 0x0 COUNT: RO; read issues req with atomic=0.
  - 0x4 COUNT_CLR: RO; read issues req with atomic=1.
  - 0x8 LAST: RO; last captured count, no request.
  - 0xC SCRATCH: RW.
- FSM states IDLE, REQ, RESP.
- IDLE, on psel&penable&!pready:
  - read 0x0/0x4: go REQ; req_o=1 and atomic_o=(offset==0x4) next edge.
  - read 0x8: prdata<=last_q, go RESP.
  - read 0xC: prdata<=scratch_q, go RESP.
  - write 0xC: scratch_q<=pwdata, go RESP.
  - write 0x0/0x4/0x8: data ignored, go RESP.
  - unmapped offsets: n/a with ADDR_W=4 (all four decoded); with wider ADDR_W, any nonzero upper bits are unmapped: read returns 0, go RESP.
- REQ: hold req_o/atomic_o until ack_i=1. On the ack edge:
  - prdata<=count_i, last_q<=count_i;
  - req_o<=0, atomic_o<=0;
  - go RESP.
- RESP: pready=1 for exactly one cycle, then IDLE. prdata holds until the next capture.
- Latency:
  - Non-counter access: access cycle N -> pready at N+1.
  - Counter read: req_o high at N+1; ack at cycle M (M>=N+1) -> pready at M+1.
- ack_i outside REQ: ignored, no state change.
- psel dropped while in REQ (protocol violation): handshake still completes; result captured into last_q; RESP pulse still issued; FSM returns to IDLE.
- Back-to-back transfers: a new access phase is accepted only in IDLE; pready is never asserted in two consecutive cycles.
- Reset mid-REQ: req_o drops immediately (async).
- pslverr=0 always unless the feature below is enabled.

Optional Feature:
- Macro: EVT_APB_TIMEOUT_EN.
- With the macro defined:
  - A wait counter runs in REQ.
  - If ack_i has not arrived after TIMEOUT_CYCLES cycles: req_o<=0, prdata<=0, pslverr<=1 with the RESP pready, last_q unchanged.
  - pslverr is also asserted for writes to RO offsets and for unmapped offsets.
  - A late ack_i after timeout is ignored.
- Without the macro: no counter, REQ waits indefinitely, pslverr tied 0.

Decomposition:
- Package evt_apb_pkg:
  - offset localparams COUNT_OFS=0x0, CLR_OFS=0x4, LAST_OFS=0x8, SCR_OFS=0xC;
  - typedef enum logic [1:0] state_t {IDLE, REQ, RESP}.
- One sub-module evt_req_initiator: owns the req_o/atomic_o/ack_i handshake, count capture and (optional) timeout counter.
- Top handles APB decode and pready/pslverr.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> all outputs 0; rst=1, no psel -> req_o stays 0.
- Read 0x0, counter acks 3 cycles after req_o rises with count_i=0x0000_0007:
  - atomic_o=0 while req_o=1;
  - prdata=0x7, pready one cycle after ack, pslverr=0.
- Read 0x4, counter acks with count_i=0x0000_0012:
  - atomic_o=1 throughout req_o;
  - prdata=0x12;
  - subsequent read 0x8 -> prdata=0x12 with no req_o activity.
- Write 0xC pwdata=0xA5A5_5A5A, then read 0xC:
  - prdata=0xA5A5_5A5A;
  - each pready exactly 1 cycle after access phase.
- Spurious ack_i pulse in IDLE, then read 0x8 -> prdata unchanged (0 after reset), no state change.
- With EVT_APB_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - read 0x0 with no ack -> req_o drops after 16 cycles; pready=1, pslverr=1, prdata=0;
  - write 0x0 -> pslverr=1.

Source files
------------

// File: rtl/evt_apb_pkg.sv
// ============================================================================
// evt_apb_pkg : register offsets and FSM state type for the APB event reader
// Revision    : 1.0
// ============================================================================
`default_nettype none

package evt_apb_pkg;

  localparam logic [3:0] COUNT_OFS = 4'h0;
  localparam logic [3:0] CLR_OFS   = 4'h4;
  localparam logic [3:0] LAST_OFS  = 4'h8;
  localparam logic [3:0] SCR_OFS   = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/evt_req_initiator.sv
// ============================================================================
// evt_req_initiator : req/atomic/ack handshake toward the event counter,
//                     count capture and optional ack timeout (EVT_APB_TIMEOUT_EN)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module evt_req_initiator #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              atomic_i,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] count_i,
  output logic              req_o,
  output logic              atomic_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] last_o
);

  logic              req_q, req_d;
  logic              atomic_q, atomic_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              timeout;

`ifdef EVT_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (start_i) begin
      wait_d = '0;
    end else if (req_q) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // An ack in the final allowed cycle still wins over the timeout.
  assign timeout = req_q & ~ack_i & (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
`endif

  // ack_i only counts while a request is outstanding; stray or late acks drop out here.
  assign done_o = req_q & (ack_i | timeout);
  assign err_o  = timeout;
  assign data_o = timeout ? '0 : count_i;
  assign req_o    = req_q;
  assign atomic_o = atomic_q;
  assign last_o   = last_q;

  always_comb begin
    req_d    = req_q;
    atomic_d = atomic_q;
    last_d   = last_q;
    if (start_i) begin
      req_d    = 1'b1;
      atomic_d = atomic_i;
    end else if (done_o) begin
      req_d    = 1'b0;
      atomic_d = 1'b0;
    end
    if (req_q && ack_i) begin
      last_d = count_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q    <= 1'b0;
      atomic_q <= 1'b0;
      last_q   <= '0;
    end else begin
      req_q    <= req_d;
      atomic_q <= atomic_d;
      last_q   <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/evt_apb_reader.sv
// ============================================================================
// evt_apb_reader : APB completer fronting the event counter; optional ack
//                  timeout and error reporting under EVT_APB_TIMEOUT_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none

module evt_apb_reader
  import evt_apb_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              req_o,
  output logic              atomic_o,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] count_i
);

`ifdef EVT_APB_TIMEOUT_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic              start;
  logic              start_atomic;
  logic              done;
  logic              cap_err;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] last;

  logic [3:0]        ofs;
  logic              unmapped;
  logic              access;
  logic              unused_addr_lsb;

  assign ofs             = {paddr[3:2], 2'b00};
  assign unused_addr_lsb = ^paddr[1:0];
  assign access          = psel & penable & ~pready_q;

  generate
    if (ADDR_W > 4) begin : g_upper_decode
      assign unmapped = |paddr[ADDR_W-1:4];
    end else begin : g_no_upper
      assign unmapped = 1'b0;
    end
  endgenerate

  evt_req_initiator #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_req (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .atomic_i (start_atomic),
    .ack_i    (ack_i),
    .count_i  (count_i),
    .req_o    (req_o),
    .atomic_o (atomic_o),
    .done_o   (done),
    .err_o    (cap_err),
    .data_o   (cap_data),
    .last_o   (last)
  );

  always_comb begin
    state_d      = state_q;
    prdata_d     = prdata_q;
    scratch_d    = scratch_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    start        = 1'b0;
    start_atomic = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d  = RESP;
          pready_d = 1'b1;
          if (unmapped) begin
            pslverr_d = ERR_EN;
            if (!pwrite) begin
              prdata_d = '0;
            end
          end else if (pwrite) begin
            if (ofs == SCR_OFS) begin
              scratch_d = pwdata;
            end else begin
              pslverr_d = ERR_EN;
            end
          end else begin
            case (ofs)
              COUNT_OFS, CLR_OFS: begin
                // Counter reads defer the response until the handshake completes.
                state_d      = REQ;
                pready_d     = 1'b0;
                start        = 1'b1;
                start_atomic = (ofs == CLR_OFS);
              end
              LAST_OFS: prdata_d = last;
              default:  prdata_d = scratch_q;
            endcase
          end
        end
      end
      REQ: begin
        if (done) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          prdata_d  = cap_data;
          pslverr_d = ERR_EN & cap_err;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      scratch_q <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      scratch_q <= scratch_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_evt_apb_reader.sv
// ============================================================================
// tb_evt_apb_reader : randomized APB/counter stimulus checked every cycle
//                     against a transaction-level model of the reader
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_evt_apb_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
`ifdef EVT_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] paddr;
  logic              psel, penable, pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;
  logic              req_o, atomic_o;
  logic              ack_i;
  logic [DATA_W-1:0] count_i;

  evt_apb_reader #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .req_o    (req_o),
    .atomic_o (atomic_o),
    .ack_i    (ack_i),
    .count_i  (count_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: register contents and what each output must show this cycle.
  logic [31:0] m_last, m_scratch, m_prdata;
  logic        exp_req, exp_atomic, exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_o",    {31'd0, req_o},    {31'd0, exp_req});
      cmp("atomic_o", {31'd0, atomic_o}, {31'd0, exp_atomic});
      cmp("pready",   {31'd0, pready},   {31'd0, exp_pready});
      cmp("pslverr",  {31'd0, pslverr},  {31'd0, exp_pslverr});
      cmp("prdata",   prdata,            exp_prdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req     = 1'b0;
    exp_atomic  = 1'b0;
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = m_prdata;
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int k = 0; k < n; k++) begin
      tick();
      psel    = 1'b0;
      penable = 1'b0;
      ack_i   = spurious ? 1'($urandom) : 1'b0;
      count_i = $urandom;
      set_idle_exp();
    end
  endtask

  // One complete APB transfer; reg_idx selects 0x0/0x4/0x8/0xC. For counter
  // reads the counter acks 'delay' cycles after req_o rises.
  task automatic xfer(input logic [1:0] reg_idx, input bit wr, input logic [31:0] wdata,
                      input int delay, input logic [31:0] cnt, input bit drop_psel);
    bit timed_out;
    int n;
    tick();
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = {reg_idx, 2'($urandom)};
    pwrite  = wr;
    pwdata  = wdata;
    ack_i   = 1'($urandom);
    count_i = $urandom;
    set_idle_exp();
    tick();
    penable = 1'b1;
    ack_i   = 1'($urandom);
    count_i = $urandom;
    set_idle_exp();
    if (!wr && reg_idx < 2) begin
      timed_out = TO_EN && (delay >= TMO);
      n = timed_out ? TMO : delay + 1;
      for (int d = 0; d < n; d++) begin
        tick();
        ack_i   = (!timed_out && d == n - 1);
        count_i = ack_i ? cnt : $urandom;
        if (drop_psel && d == 0) begin
          psel    = 1'b0;
          penable = 1'b0;
        end
        exp_req     = 1'b1;
        exp_atomic  = (reg_idx == 2'd1);
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = m_prdata;
      end
      tick();
      ack_i   = timed_out ? 1'($urandom) : 1'b0;
      count_i = $urandom;
      if (timed_out) begin
        m_prdata = 32'd0;
      end else begin
        m_prdata = cnt;
        m_last   = cnt;
      end
      exp_req     = 1'b0;
      exp_atomic  = 1'b0;
      exp_pready  = 1'b1;
      exp_pslverr = timed_out;
      exp_prdata  = m_prdata;
    end else begin
      tick();
      ack_i = 1'b0;
      if (wr) begin
        if (reg_idx == 2'd3) m_scratch = wdata;
      end else begin
        m_prdata = (reg_idx == 2'd2) ? m_last : m_scratch;
      end
      exp_req     = 1'b0;
      exp_atomic  = 1'b0;
      exp_pready  = 1'b1;
      exp_pslverr = TO_EN && wr && (reg_idx != 2'd3);
      exp_prdata  = m_prdata;
    end
    tick();
    psel    = 1'b0;
    penable = 1'b0;
    ack_i   = 1'b0;
    set_idle_exp();
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    #1;
    cmp(name, prdata, exp);
  endtask

  initial begin
    rst      = 1'b0;
    paddr    = '0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    pwdata   = '0;
    ack_i    = 1'b0;
    count_i  = '0;
    m_last   = '0;
    m_scratch = '0;
    m_prdata = '0;
    set_idle_exp();
    chk_en = 1'b1;

    repeat (2) tick();
    rst = 1'b1;
    idle(3, 1'b0);

    xfer(2'd0, 1'b0, 32'd0, 3, 32'h0000_0007, 1'b0);
    lit("lit_count_read", 32'h0000_0007);
    xfer(2'd1, 1'b0, 32'd0, 2, 32'h0000_0012, 1'b0);
    lit("lit_clr_read", 32'h0000_0012);
    xfer(2'd2, 1'b0, 32'd0, 0, 32'd0, 1'b0);
    lit("lit_last_read", 32'h0000_0012);
    xfer(2'd3, 1'b1, 32'hA5A5_5A5A, 0, 32'd0, 1'b0);
    xfer(2'd3, 1'b0, 32'd0, 0, 32'd0, 1'b0);
    lit("lit_scratch_read", 32'hA5A5_5A5A);

    // Asynchronous reset while a counter request is outstanding.
    tick();
    psel = 1'b1; penable = 1'b0; paddr = 4'h0; pwrite = 1'b0;
    set_idle_exp();
    tick();
    penable = 1'b1;
    set_idle_exp();
    tick();
    exp_req = 1'b1; exp_atomic = 1'b0;
    tick();
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    cmp("async_req_drop", {31'd0, req_o}, 32'd0);
    cmp("async_prdata_clr", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    m_last = '0; m_scratch = '0; m_prdata = '0;
    set_idle_exp();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;

    idle(4, 1'b1);
    xfer(2'd2, 1'b0, 32'd0, 0, 32'd0, 1'b0);
    lit("lit_last_after_spurious", 32'd0);
    xfer(2'd3, 1'b0, 32'd0, 0, 32'd0, 1'b0);
    lit("lit_scratch_after_reset", 32'd0);

    for (int i = 0; i < 200; i++) begin
      xfer(2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 7), $urandom,
           ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2), 1'b1);
    end

`ifdef EVT_APB_TIMEOUT_EN
    xfer(2'd0, 1'b0, 32'd0, 20, 32'hDEAD_BEEF, 1'b0);
    lit("lit_timeout_prdata", 32'd0);
    xfer(2'd0, 1'b1, 32'h1234_5678, 0, 32'd0, 1'b0);
`endif

    idle(2, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
